// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store against a word-organised RAM,
// answering after a fixed, parameterised number of access cycles.
module dmem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   output logic [31:0] rdata,
   output logic        resp_valid,
   output logic        stall,
   output logic        err
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP,
      S_ERROR
   } state_t;

   // Accepted request, already reduced to word index, lane strobes and lane-replicated data.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] widx;
      logic [3:0]        be;
      logic [31:0]       wdata;
   } req_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   req_t               req_q, req_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               resp_valid_q, resp_valid_d;
   logic               err_q, err_d;
   logic               mem_we;
   logic [31:0]        mem [DEPTH];

   logic               aligned;
   logic [3:0]         be_new;
   logic [31:0]        wdata_new;
   logic               unused_addr_hi;

   // Addresses above the RAM alias onto it.
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   // Size decode: alignment, byte strobes and lane replication of store data.
   always_comb begin
      aligned   = 1'b0;
      be_new    = 4'b0000;
      wdata_new = req_wdata;
      case (req_size)
         2'b00: begin
            aligned   = 1'b1;
            be_new    = 4'(4'b0001 << req_addr[1:0]);
            wdata_new = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            aligned   = ~req_addr[0];
            be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            aligned   = (req_addr[1:0] == 2'b00);
            be_new    = 4'b1111;
         end
         default: begin
            aligned   = 1'b0;
         end
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      rdata_d      = rdata_q;
      resp_valid_d = 1'b0;
      err_d        = 1'b0;
      mem_we       = 1'b0;
      stall        = 1'b0;

      case (state_q)
         S_IDLE: begin
            stall = req_valid;
            if (req_valid) begin
               if (!aligned) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end else begin
                  req_d.we    = req_we;
                  req_d.widx  = req_addr[ADDR_W+1:2];
                  req_d.be    = be_new;
                  req_d.wdata = wdata_new;
                  cnt_d       = CNT_W'(LATENCY - 1);
                  state_d     = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            stall = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               if (req_q.we) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = mem[req_q.widx];
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         S_ERROR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
         err_q        <= err_d;
      end
   end

   // RAM write port; a reset in the commit cycle suppresses the store.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         if (req_q.be[0]) mem[req_q.widx][7:0]   <= req_q.wdata[7:0];
         if (req_q.be[1]) mem[req_q.widx][15:8]  <= req_q.wdata[15:8];
         if (req_q.be[2]) mem[req_q.widx][23:16] <= req_q.wdata[23:16];
         if (req_q.be[3]) mem[req_q.widx][31:24] <= req_q.wdata[31:24];
      end
   end

   assign rdata      = rdata_q;
   assign resp_valid = resp_valid_q;
   assign err        = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the core's memory-stage load/store interface.
- Accepts one request at a time from the pipeline: address, write flag, store data and access size.
- Performs the access on an internal word-organised RAM after a programmable latency, holding the pipeline stalled until the response is ready.
- Returns the full aligned 32-bit word. The core's truncate logic extracts the byte or halfword using address bits [1:0], so the responder never shifts read data.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2^ADDR_W words.
- LATENCY, 2, cycles spent in ACCESS before the response; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  memory-stage request present; held stable by the core while stall is high.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result from the memory stage).
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- rdata  out  32  aligned word read; valid only while resp_valid is high.
- resp_valid  out  1  one-cycle response pulse, for both loads and stores.
- stall  out  1  freezes the pipeline while a request is outstanding.
- err  out  1  one-cycle pulse on a misaligned or illegal-size request.

Behaviour:
- State machine has four states: IDLE, ACCESS, RESP, ERROR.
- Reset values: state = IDLE, cnt = 0, rdata = 0, resp_valid = 0, err = 0. RAM contents are not reset.
- Reset asserted mid-operation:
  - Aborts to IDLE with no response.
  - A store not yet committed is never written.
- stall (combinational):
  - IDLE: stall = req_valid.
  - ACCESS: stall = 1.
  - RESP and ERROR: stall = 0.
- IDLE, on req_valid:
  - Alignment check: byte is always aligned; half requires addr[0] = 0; word requires addr[1:0] = 0; size 11 is always illegal.
  - Illegal or misaligned: go to ERROR, no RAM access.
  - Otherwise: latch we/addr/wdata/size, load cnt = LATENCY-1, go to ACCESS.
- ACCESS:
  - If cnt != 0: decrement cnt and stay.
  - If cnt == 0, commit the access on that edge. A store writes the RAM with byte strobes; a load registers mem[word index] into rdata. Then go to RESP.
- RESP:
  - resp_valid = 1; rdata holds the load word. After a store, rdata holds the previous value and is don't-care.
  - Always go to IDLE next cycle. req_valid is ignored in RESP because the core's request is still the completed one.
- ERROR: err = 1 for one cycle, then go to IDLE.
- Timing:
  - Request first seen in cycle 0 produces resp_valid in cycle LATENCY+1.
  - stall is high in cycles 0..LATENCY, i.e. LATENCY+1 stall cycles.
  - Back-to-back requests are accepted no earlier than the cycle after RESP.
- Word index is req_addr[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses alias.
- Byte strobes:
  - Byte: strobe = 0001 << addr[1:0]; wdata[7:0] replicated on all four lanes.
  - Half: strobe = addr[1] ? 1100 : 0011; wdata[15:0] replicated on both halves.
  - Word: strobe = 1111.
  - Only strobed bytes change.
- rdata and resp_valid are registered outputs; stall is the only combinational output.

Test Plan:
- Reset, then a word store (LATENCY=2, addr 0x10, wdata 0xDEADBEEF, size 10) -> stall high cycles 0-2, resp_valid in cycle 3; a following word load from 0x10 returns rdata 0xDEADBEEF 3 cycles after issue.
- Byte store of 0xAB to 0x13 over word 0x11223344 -> load from 0x10 returns 0xAB223344; half store of 0x5566 to 0x10 -> next load returns 0xAB225566.
- Misaligned requests: half at 0x21, word at 0x22, size 11 at 0x20 -> err pulses 1 cycle each, stall low in the ERROR cycle, no resp_valid, memory unchanged (verify by load).
- LATENCY=1 and LATENCY=15 builds -> resp_valid exactly LATENCY+1 cycles after request; stall high for exactly LATENCY+1 cycles.
- Reset asserted in the 2nd ACCESS cycle of a store to 0x40 (old 0x00000000) -> no resp_valid, all outputs 0 next cycle, subsequent load returns 0x00000000.
- Aliasing: ADDR_W=10, store 0x12345678 to 0x00001004 -> load from 0x00000004 returns 0x12345678.
